// File: rtl/bidir_bus_arbiter_if.sv
// bidir_bus_arbiter_if: request/grant and buffer-control bundle between the
// half-duplex direction arbiter and the two requesting agents.
//   master : arbiter side (samples requests, drives grants/enables/direction)
//   slave  : agent side (drives requests, observes grants/enables/direction)
interface bidir_bus_arbiter_if;
  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;
  logic oe_a;
  logic oe_b;
  logic en;
  logic turn;

  modport master (
    input  req_a, req_b,
    output gnt_a, gnt_b, oe_a, oe_b, en, turn
  );

  modport slave (
    output req_a, req_b,
    input  gnt_a, gnt_b, oe_a, oe_b, en, turn
  );
endinterface

// File: rtl/bidir_bus_arbiter.sv
// bidir_bus_arbiter: half-duplex direction controller for the shared
// bidirectional buffer. Side A drives toward B (en=1), side B drives toward A
// (en=0). Every direction change inserts TURN_CYCLES dead cycles with both
// tristate drivers off. All outputs are registered (Moore).
// Optional feature macro: BIDIR_ARB_BURST_LIMIT_EN -- when defined, an owner
// is forced to yield after MAX_BURST grant cycles while the other side
// requests; when undefined the owner keeps the bus until its request drops.
module bidir_bus_arbiter #(
  parameter int TURN_CYCLES = 1,
  parameter int MAX_BURST   = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  bidir_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN  = 2'd1,
    ST_OWN_A = 2'd2,
    ST_OWN_B = 2'd3
  } state_t;

  // A side is encoded with the buffer direction it needs, so a side value can
  // be compared against / loaded into en directly.
  localparam logic SIDE_A = 1'b1;
  localparam logic SIDE_B = 1'b0;

  localparam int              TW        = $clog2(TURN_CYCLES + 1);
  localparam logic [TW-1:0]   TURN_ONE  = TW'(1'b1);
  localparam logic [TW-1:0]   TURN_LAST = TW'(TURN_CYCLES);

  // An illegal configuration keeps the bus parked and undriven.
  localparam logic CFG_OK = (TURN_CYCLES > 32'sd0) && (MAX_BURST > 32'sd0);

  state_t        state_r, state_nx_s;
  logic          target_r, target_nx_s;
  logic          last_owner_r, last_owner_nx_s;
  logic [TW-1:0] turn_cnt_r, turn_cnt_nx_s;
  logic          en_r, en_nx_s;
  logic          gnt_a_r, gnt_b_r, oe_a_r, oe_b_r, turn_r;
  logic          winner_s;
  logic          req_tgt_s;
  logic          burst_yield_s;

`ifdef BIDIR_ARB_BURST_LIMIT_EN
  localparam int            BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_ONE = BW'(1'b1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  logic [BW-1:0] burst_cnt_r, burst_cnt_nx_s;

  // Saturating count of consecutive grant cycles of the current owner.
  always_comb begin
    burst_cnt_nx_s = '0;
    if ((state_nx_s == ST_OWN_A) || (state_nx_s == ST_OWN_B)) begin
      if (state_nx_s != state_r) begin
        burst_cnt_nx_s = BURST_ONE;
      end else if (burst_cnt_r != BURST_MAX) begin
        burst_cnt_nx_s = burst_cnt_r + BURST_ONE;
      end else begin
        burst_cnt_nx_s = burst_cnt_r;
      end
    end else begin
      burst_cnt_nx_s = '0;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_r <= '0;
    end else begin
      burst_cnt_r <= burst_cnt_nx_s;
    end
  end

  assign burst_yield_s = (burst_cnt_r == BURST_MAX);
`else
  assign burst_yield_s = 1'b0;
`endif

  // Round-robin winner and the request of the locked turnaround target.
  always_comb begin
    winner_s  = SIDE_B;
    req_tgt_s = (target_r == SIDE_A) ? bus.req_a : bus.req_b;
    if (bus.req_a && bus.req_b) begin
      winner_s = ~last_owner_r;
    end else if (bus.req_a) begin
      winner_s = SIDE_A;
    end else begin
      winner_s = SIDE_B;
    end
  end

  // Next-state decode; a TURN entry also flips en and locks the target.
  always_comb begin
    state_nx_s      = state_r;
    target_nx_s     = target_r;
    last_owner_nx_s = last_owner_r;
    turn_cnt_nx_s   = turn_cnt_r;
    en_nx_s         = en_r;
    case (state_r)
      ST_IDLE: begin
        if (CFG_OK && (bus.req_a || bus.req_b)) begin
          if (winner_s == en_r) begin
            state_nx_s      = (winner_s == SIDE_A) ? ST_OWN_A : ST_OWN_B;
            last_owner_nx_s = winner_s;
          end else begin
            state_nx_s    = ST_TURN;
            target_nx_s   = winner_s;
            en_nx_s       = winner_s;
            turn_cnt_nx_s = TURN_ONE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_TURN: begin
        if (turn_cnt_r == TURN_LAST) begin
          if (req_tgt_s) begin
            state_nx_s      = (target_r == SIDE_A) ? ST_OWN_A : ST_OWN_B;
            last_owner_nx_s = target_r;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          turn_cnt_nx_s = turn_cnt_r + TURN_ONE;
        end
      end
      ST_OWN_A: begin
        if ((!bus.req_a || burst_yield_s) && bus.req_b) begin
          state_nx_s    = ST_TURN;
          target_nx_s   = SIDE_B;
          en_nx_s       = SIDE_B;
          turn_cnt_nx_s = TURN_ONE;
        end else if (!bus.req_a) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_OWN_A;
        end
      end
      ST_OWN_B: begin
        if ((!bus.req_b || burst_yield_s) && bus.req_a) begin
          state_nx_s    = ST_TURN;
          target_nx_s   = SIDE_A;
          en_nx_s       = SIDE_A;
          turn_cnt_nx_s = TURN_ONE;
        end else if (!bus.req_b) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_OWN_B;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, bookkeeping and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      target_r     <= SIDE_B;
      last_owner_r <= SIDE_B;
      turn_cnt_r   <= '0;
      en_r         <= 1'b0;
      gnt_a_r      <= 1'b0;
      gnt_b_r      <= 1'b0;
      oe_a_r       <= 1'b0;
      oe_b_r       <= 1'b0;
      turn_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      target_r     <= target_nx_s;
      last_owner_r <= last_owner_nx_s;
      turn_cnt_r   <= turn_cnt_nx_s;
      en_r         <= en_nx_s;
      gnt_a_r      <= (state_nx_s == ST_OWN_A);
      gnt_b_r      <= (state_nx_s == ST_OWN_B);
      oe_a_r       <= (state_nx_s == ST_OWN_A);
      oe_b_r       <= (state_nx_s == ST_OWN_B);
      turn_r       <= (state_nx_s == ST_TURN);
    end
  end

  assign bus.gnt_a = gnt_a_r;
  assign bus.gnt_b = gnt_b_r;
  assign bus.oe_a  = oe_a_r;
  assign bus.oe_b  = oe_b_r;
  assign bus.en    = en_r;
  assign bus.turn  = turn_r;

endmodule
